// File: rtl/fft_block_loader.sv
// rtl/fft_block_loader.sv - serial-to-8-lane block assembler for the twiddle stage
// Collects eight samples per block and presents them with a one-cycle strobe and twiddle step index.
module fft_block_loader #(
  parameter int WIDTH        = 16,
  parameter int FRAME_BLOCKS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sop,
  input  logic [WIDTH-1:0]     in_re,
  input  logic [WIDTH-1:0]     in_im,
  output logic [8*WIDTH-1:0]   out_x,
  output logic [8*WIDTH-1:0]   out_xi,
  output logic [5:0]           out_start,
  output logic [5:0]           out_step,
  output logic                 out_valid,
  output logic                 out_last,
  output logic                 err_align
);

  localparam int            BW       = (FRAME_BLOCKS > 1) ? $clog2(FRAME_BLOCKS) : 1;
  localparam logic [BW-1:0] BLK_LAST = BW'(FRAME_BLOCKS - 1);

  logic [2:0]         lane_cnt_q, lane_cnt_d;
  logic [BW-1:0]      blk_cnt_q, blk_cnt_d;
  logic [8*WIDTH-1:0] coll_re_q, coll_re_d;
  logic [8*WIDTH-1:0] coll_im_q, coll_im_d;
  logic [8*WIDTH-1:0] out_x_q, out_x_d;
  logic [8*WIDTH-1:0] out_xi_q, out_xi_d;
  logic [5:0]         out_step_q, out_step_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               err_align_q, err_align_d;

  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    blk_cnt_d   = blk_cnt_q;
    coll_re_d   = coll_re_q;
    coll_im_d   = coll_im_q;
    out_x_d     = out_x_q;
    out_xi_d    = out_xi_q;
    out_step_d  = out_step_q;
    out_last_d  = out_last_q;
    out_valid_d = 1'b0;
    err_align_d = 1'b0;

    if (in_valid && in_sop) begin
      // Realign beats block completion: a sop on lane 7 starts a new block 0 without a strobe.
      coll_re_d[0 +: WIDTH] = in_re;
      coll_im_d[0 +: WIDTH] = in_im;
      lane_cnt_d  = 3'd1;
      blk_cnt_d   = '0;
      err_align_d = (lane_cnt_q != 3'd0) || (blk_cnt_q != '0);
    end else if (in_valid) begin
      coll_re_d[int'(lane_cnt_q)*WIDTH +: WIDTH] = in_re;
      coll_im_d[int'(lane_cnt_q)*WIDTH +: WIDTH] = in_im;
      lane_cnt_d = lane_cnt_q + 3'd1;
      if (lane_cnt_q == 3'd7) begin
        // Current sample bypasses the collection register straight into lane 7.
        out_x_d     = {in_re, coll_re_q[7*WIDTH-1:0]};
        out_xi_d    = {in_im, coll_im_q[7*WIDTH-1:0]};
        out_step_d  = 6'(blk_cnt_q);
        out_last_d  = (blk_cnt_q == BLK_LAST);
        out_valid_d = 1'b1;
        blk_cnt_d   = (blk_cnt_q == BLK_LAST) ? '0 : blk_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_q  <= '0;
      blk_cnt_q   <= '0;
      coll_re_q   <= '0;
      coll_im_q   <= '0;
      out_x_q     <= '0;
      out_xi_q    <= '0;
      out_step_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      coll_re_q   <= coll_re_d;
      coll_im_q   <= coll_im_d;
      out_x_q     <= out_x_d;
      out_xi_q    <= out_xi_d;
      out_step_q  <= out_step_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      err_align_q <= err_align_d;
    end
  end

  assign out_x     = out_x_q;
  assign out_xi    = out_xi_q;
  assign out_start = 6'd0;
  assign out_step  = out_step_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign err_align = err_align_q;

endmodule

// File: tb/tb_fft_block_loader.sv
// tb/tb_fft_block_loader.sv - self-checking bench for fft_block_loader
// Table-driven gapped stream plus hand sequences; expected blocks queued by a reference model.
module tb_fft_block_loader;

  localparam int W  = 16;
  localparam int FB = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_sop;
  logic [W-1:0]   in_re, in_im;
  logic [8*W-1:0] out_x, out_xi;
  logic [5:0]     out_start, out_step;
  logic           out_valid, out_last, err_align;

  always #5 clk = ~clk;

  fft_block_loader #(.WIDTH(W), .FRAME_BLOCKS(FB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
    .in_re(in_re), .in_im(in_im), .out_x(out_x), .out_xi(out_xi),
    .out_start(out_start), .out_step(out_step), .out_valid(out_valid),
    .out_last(out_last), .err_align(err_align)
  );

  typedef struct {
    logic [8*W-1:0] x;
    logic [8*W-1:0] xi;
    logic [5:0]     step;
    logic           last;
  } blk_t;

  typedef struct {
    bit         v;
    bit         sop;
    logic [W-1:0] re;
    logic [W-1:0] im;
    bit         ev;
    bit         ee;
  } vec_t;

  blk_t     sb[$];
  blk_t     held;
  logic [W-1:0] m_re[8];
  logic [W-1:0] m_im[8];
  int       m_lane, m_blk;
  int       n_vec = 0, n_err = 0;
  int       cyc = 0, last_strobe = -100, strobe_gap = 0;
  bit       exp_v, exp_e;
  vec_t     tbl[32];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_lane = 0;
    m_blk  = 0;
    sb.delete();
    held = '{x: '0, xi: '0, step: '0, last: 1'b0};
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_x"},     128'(out_x),     128'(0));
    check({tag, "_xi"},    128'(out_xi),    128'(0));
    check({tag, "_step"},  128'(out_step),  128'(0));
    check({tag, "_start"}, 128'(out_start), 128'(0));
    check({tag, "_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_last"},  128'(out_last),  128'(0));
    check({tag, "_err"},   128'(err_align), 128'(0));
  endtask

  task automatic drive(input bit v, input bit sop, input logic [W-1:0] re, input logic [W-1:0] im);
    blk_t b;
    in_valid = v; in_sop = sop; in_re = re; in_im = im;
    exp_v = 1'b0; exp_e = 1'b0;
    if (v) begin
      if (sop) begin
        exp_e = (m_lane != 0) || (m_blk != 0);
        m_re[0] = re; m_im[0] = im;
        m_lane = 1; m_blk = 0;
      end else begin
        m_re[m_lane] = re; m_im[m_lane] = im;
        if (m_lane == 7) begin
          for (int j = 0; j < 8; j++) begin
            b.x[j*W +: W]  = m_re[j];
            b.xi[j*W +: W] = m_im[j];
          end
          b.step = 6'(m_blk);
          b.last = (m_blk == FB-1);
          sb.push_back(b);
          exp_v  = 1'b1;
          m_lane = 0;
          m_blk  = (m_blk + 1) % FB;
        end else begin
          m_lane++;
        end
      end
    end
    @(posedge clk);
    #2;
    cyc++;
    check("out_valid", 128'(out_valid), 128'(exp_v));
    check("err_align", 128'(err_align), 128'(exp_e));
    check("out_start", 128'(out_start), 128'(0));
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL strobe: got unexpected strobe expected none (cycle %0d)", cyc);
      end else begin
        held = sb.pop_front();
        strobe_gap  = cyc - last_strobe;
        last_strobe = cyc;
      end
    end
    check("out_x",    128'(out_x),    128'(held.x));
    check("out_xi",   128'(out_xi),   128'(held.xi));
    check("out_step", 128'(out_step), 128'(held.step));
    check("out_last", 128'(out_last), 128'(held.last));
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0; in_sop = 1'b0;
    rst = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    int strobes;
    logic [W-1:0] sop_val;

    for (int i = 0; i < 32; i++) begin
      tbl[i].v   = (i % 2 == 0);
      tbl[i].sop = (i == 0);
      tbl[i].re  = W'(i / 2);
      tbl[i].im  = W'(-(i / 2));
      tbl[i].ev  = (i == 14) || (i == 30);
      tbl[i].ee  = 1'b0;
    end

    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_re = '0; in_im = '0;
    model_reset();
    #12;
    check_zero("reset");
    @(posedge clk);
    #3;
    rst = 1'b0;

    // gapped input, table-driven
    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].v, tbl[i].sop, tbl[i].re, tbl[i].im);
      check("tbl_valid", 128'(out_valid), 128'(tbl[i].ev));
      check("tbl_err",   128'(err_align), 128'(tbl[i].ee));
    end

    // reset mid-block with 5 samples collected
    for (int n = 0; n < 5; n++) drive(1'b1, 1'b0, W'(100 + n), W'(200 + n));
    do_reset("midrst");
    for (int n = 0; n < 8; n++) drive(1'b1, 1'b0, W'(300 + n), W'(400 + n));
    check("midrst_step", 128'(out_step), 128'(0));
    check("midrst_lane0", 128'(out_x[0 +: W]), 128'(300));

    // continuous frame of 64 samples
    do_reset("prefrm");
    strobes = 0;
    for (int n = 0; n < 64; n++) begin
      drive(1'b1, n == 0, W'(n), W'(-n));
      if (out_valid) begin
        if (strobes > 0) check("cont_gap", 128'(strobe_gap), 128'(8));
        check("cont_step", 128'(out_step), 128'(strobes));
        strobes++;
      end
    end
    check("cont_strobes", 128'(strobes), 128'(8));

    // sop with in_valid low is ignored, sop on frame boundary is silent
    drive(1'b0, 1'b1, 16'h1111, 16'h2222);
    drive(1'b1, 1'b1, 16'h0A00, 16'h0B00);
    check("bnd_err", 128'(err_align), 128'(0));
    for (int n = 1; n < 8; n++) drive(1'b1, 1'b0, W'(16'h0A00 + n), W'(16'h0B00 + n));
    check("bnd_step", 128'(out_step), 128'(0));

    // early sop on 4th sample of block 2
    for (int n = 0; n < 8; n++) drive(1'b1, 1'b0, W'(n), W'(n));
    for (int n = 0; n < 3; n++) drive(1'b1, 1'b0, W'(50 + n), W'(60 + n));
    sop_val = 16'h5A5A;
    drive(1'b1, 1'b1, sop_val, 16'hA5A5);
    check("early_err", 128'(err_align), 128'(1));
    for (int n = 1; n < 8; n++) drive(1'b1, 1'b0, W'(70 + n), W'(80 + n));
    check("early_step",  128'(out_step), 128'(0));
    check("early_lane0", 128'(out_x[0 +: W]), 128'(sop_val));

    // sop on the lane-7 sample: realign wins, no strobe
    for (int n = 0; n < 7; n++) drive(1'b1, 1'b0, W'(90 + n), W'(91 + n));
    drive(1'b1, 1'b1, 16'h0777, 16'h0888);
    check("l7sop_valid", 128'(out_valid), 128'(0));
    check("l7sop_err",   128'(err_align), 128'(1));
    for (int n = 1; n < 8; n++) drive(1'b1, 1'b0, W'(n), W'(n));
    check("l7sop_lane0", 128'(out_x[0 +: W]), 128'(16'h0777));

    // extremes, then hold while the next block is collected
    for (int n = 0; n < 8; n++)
      drive(1'b1, 1'b0, (n % 2 == 0) ? 16'h7FFF : 16'h8000, (n % 2 == 0) ? 16'h8000 : 16'h7FFF);
    check("ext_x", 128'(out_x), 128'({4{16'h8000, 16'h7FFF}}));
    for (int n = 0; n < 7; n++) drive(1'b1, 1'b0, W'(n + 1), W'(n + 1));
    check("ext_hold", 128'(out_xi), 128'({4{16'h7FFF, 16'h8000}}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_block_loader.md
# fft_block_loader

Serial-to-block front end for the twiddle stage. Accepts one complex sample per clock, assembles eight consecutive samples into an 8-lane vector, and issues it with a one-cycle valid strobe and the twiddle `start`/`step` indices. It sits directly upstream of the complex multiplier and drives that block's `x`, `xi`, `start`, `step` and `isValid` inputs. Blocks are counted within a frame so that block `k` is rotated by W64^(k·j) on lane `j`.

## Interface
Parameters:
- `WIDTH`, 16: sample component width, signed two's complement.
- `FRAME_BLOCKS`, 8: blocks per frame; power of two, 1..64.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: sample present this cycle.
- `in_sop`  in  1: start of frame; qualified by `in_valid`.
- `in_re`  in  WIDTH: sample real part.
- `in_im`  in  WIDTH: sample imaginary part.
- `out_x`  out  WIDTH×[0:7]: block real parts, lane j = j-th sample of block.
- `out_xi`  out  WIDTH×[0:7]: block imaginary parts.
- `out_start`  out  6: twiddle start index, always 0.
- `out_step`  out  6: twiddle step = block index within frame.
- `out_valid`  out  1: one-cycle strobe; block on outputs is new.
- `out_last`  out  1: block is the final block of the frame; valid with `out_valid`.
- `err_align`  out  1: one-cycle pulse; frame realigned by early `in_sop`.

## Operation
- Internal state:
  - `lane_cnt`: 3-bit write lane.
  - `blk_cnt`: log2(FRAME_BLOCKS)-bit block index.
  - Collection register: 8×2×WIDTH.
  - Output register, separate from collection, so collection of block n+1 overlaps presentation of block n.
- Each accepted sample (`in_valid`=1) is written to collection lane `lane_cnt`, then `lane_cnt` increments.
- On the sample that fills lane 7:
  - Collection lanes 0..6 plus the current sample are copied to the output register in the same edge.
  - `out_step` ← `blk_cnt`; `out_last` ← (`blk_cnt` == FRAME_BLOCKS−1); `out_valid` ← 1.
  - `lane_cnt` wraps to 0; `blk_cnt` increments, wrapping at FRAME_BLOCKS.
- `in_valid`=0: no state change. Gaps between samples are allowed anywhere; lane position is preserved.
- `in_sop` with `in_valid`=0: ignored.
- `in_sop`=1 with `in_valid`=1:
  - Sample is forced to lane 0 of block 0; `lane_cnt` ← 1, `blk_cnt` ← 0.
  - Any partially collected block is discarded and never output.
  - `err_align` pulses if `lane_cnt`≠0 or `blk_cnt`≠0 before the edge, i.e. the previous frame was short or misaligned. An `in_sop` exactly on a frame boundary is silent.
  - A frame with no `in_sop` is legal: counters free-run.
- Output register, `out_step`, `out_last` and `out_start` hold their value between strobes.
- No backpressure. The downstream stage accepts every strobe; the minimum strobe spacing is 8 cycles.
- No arithmetic on data: samples are passed bit-exact. `out_step` is zero-extended to 6 bits.

## Timing
- Latency: if the lane-7 sample is accepted at edge t, `out_valid`=1 for the cycle after edge t and the new data are stable from edge t.
- `out_valid` and `err_align` are registered, one cycle wide.
- Reset, asynchronous assert, all to 0: `out_x`, `out_xi`, `out_start`, `out_step`, `out_valid`, `out_last`, `err_align`, `lane_cnt`, `blk_cnt`, collection register.
- Reset mid-block discards the partial block. The first sample after release is lane 0 of block 0.
- `in_sop` on the lane-7 sample of a block: the realign rule wins. No strobe is issued, and the sample becomes lane 0 of a new block 0.

## Test plan
- **Reset:** assert `rst` mid-stream with 5 samples collected -> all outputs 0 immediately; after release, the next 8 samples produce a strobe with `out_step`=0.
- **Continuous frame:** 64 back-to-back samples, re=n, im=−n, `in_sop` on n=0 ->
  - 8 strobes exactly 8 cycles apart.
  - Block k has `out_x[j]`=8k+j, `out_xi[j]`=−(8k+j), `out_step`=k.
  - `out_last` only on k=7.
  - `err_align` never pulses.
- **Gapped input:** `in_valid` toggled 1,0,1,0 over 16 samples -> 2 strobes; the data match the continuous case; the strobe follows the 8th accepted sample by 1 cycle.
- **Early sop:** `in_sop` on the 4th sample of block 2 -> `err_align` pulses once; no strobe for the partial block; the next strobe has `out_step`=0 and lane 0 equal to the sop sample.
- **Boundary sop:** `in_sop` on the first sample after block 7 -> no `err_align`; `out_step` restarts at 0. Also, `in_sop` with `in_valid`=0 -> no effect.
- **Extremes:** samples 0x7FFF and 0x8000 alternating -> output lanes bit-exact; the output register holds its value across the following 7 cycles while the next block is collected.
